// File: rtl/data_memory_if.sv
// Load/store port bundle between the pipeline (master) and the data memory (slave).
interface data_memory_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_write;
   logic        mem_read;
   logic [1:0]  width;
   logic        load_unsigned;
   logic [31:0] pc;
   logic [31:0] rdata;
   logic        misalign;
   logic        err_sticky;
   logic [15:0] store_cnt;

   modport master (
      output addr, wdata, mem_write, mem_read, width, load_unsigned, pc,
      input  rdata, misalign, err_sticky, store_cnt
   );

   modport slave (
      input  addr, wdata, mem_write, mem_read, width, load_unsigned, pc,
      output rdata, misalign, err_sticky, store_cnt
   );
endinterface

// File: rtl/data_memory.sv
// 4 KiB byte-addressable data memory with alignment/range checks and a store counter.
// Optional macro DM_WRITE_LOG_EN prints one line per committed store.
module data_memory (
   input  logic          clk,
   input  logic          rst_n,
   data_memory_if.slave  bus
);
   localparam int unsigned DEPTH   = 1024;
   localparam int unsigned AW      = 10;
   localparam int unsigned DW      = 32;
   localparam int unsigned CNT_W   = 16;
   localparam logic [1:0]  W_HALF  = 2'b01;
   localparam logic [1:0]  W_BYTE  = 2'b10;

   logic [DW-1:0]    mem_q [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [AW-1:0]    idx;
   logic             in_range;
   logic             unaligned;
   logic             misalign_c;
   logic             wr_en;
   logic [DW-1:0]    cur_word;
   logic [DW-1:0]    wr_word;
   logic [DW-1:0]    rdata_c;

   assign idx = bus.addr[11:2];

   // A word never written since reset reads as zero, which gives the array a full async clear.
   assign cur_word = valid_q[idx] ? mem_q[idx] : '0;

   // Fault detection
   always_comb begin
      in_range  = (bus.addr[31:12] == 20'd0);
      unaligned = 1'b0;
      case (bus.width)
         W_HALF:  unaligned = bus.addr[0];
         W_BYTE:  unaligned = 1'b0;
         default: unaligned = (bus.addr[1:0] != 2'b00);
      endcase
      misalign_c = (bus.mem_read | bus.mem_write) & (unaligned | ~in_range);
      wr_en      = bus.mem_write & ~misalign_c;
   end

   // Lane-merged store word
   always_comb begin
      logic [3:0]    be;
      logic [DW-1:0] wrep;
      be   = 4'b1111;
      wrep = bus.wdata;
      case (bus.width)
         W_HALF: begin
            be   = bus.addr[1] ? 4'b1100 : 4'b0011;
            wrep = {2{bus.wdata[15:0]}};
         end
         W_BYTE: begin
            be   = 4'(4'b0001 << bus.addr[1:0]);
            wrep = {4{bus.wdata[7:0]}};
         end
         default: begin
            be   = 4'b1111;
            wrep = bus.wdata;
         end
      endcase
      wr_word = cur_word;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) wr_word[b*8 +: 8] = wrep[b*8 +: 8];
      end
   end

   // Load path: lane select and extension, zero when idle or faulting
   always_comb begin
      logic [DW-1:0] shifted;
      logic [15:0]   half;
      rdata_c = '0;
      shifted = cur_word >> 5'({bus.addr[1:0], 3'b000});
      half    = bus.addr[1] ? cur_word[31:16] : cur_word[15:0];
      if (bus.mem_read && !misalign_c) begin
         case (bus.width)
            W_HALF:  rdata_c = bus.load_unsigned ? {16'd0, half}
                                                 : {{16{half[15]}}, half};
            W_BYTE:  rdata_c = bus.load_unsigned ? {24'd0, shifted[7:0]}
                                                 : {{24{shifted[7]}}, shifted[7:0]};
            default: rdata_c = cur_word;
         endcase
      end
   end

   always_comb begin
      valid_d = valid_q;
      if (wr_en) valid_d[idx] = 1'b1;
      err_d = err_q | misalign_c;
      cnt_d = cnt_q + CNT_W'(wr_en);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Data array needs no reset: valid_q masks stale contents, and reset blocks the write.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) mem_q[idx] <= wr_word;
   end

`ifdef DM_WRITE_LOG_EN
   always_ff @(posedge clk) begin
      if (rst_n && wr_en)
         $display("@%h: *%h <= %h", bus.pc, {bus.addr[31:2], 2'b00}, wr_word);
   end
`else
   logic unused_pc;
   assign unused_pc = ^bus.pc;
`endif

   assign bus.rdata      = rdata_c;
   assign bus.misalign   = misalign_c;
   assign bus.err_sticky = err_q;
   assign bus.store_cnt  = cnt_q;

endmodule
